// File: rtl/miriscv_data_mem.sv
// Word-addressed data memory responder for the core's data bus.
// Each access is held off by a programmable number of stall cycles. Accesses outside the window are flagged.
module miriscv_data_mem #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk_i,
    input  logic        arstn_i,
    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic [31:0] data_rdata_o,
    output logic        data_stall_o,
    output logic        data_err_o
);

    localparam int unsigned AW           = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] WINDOW_BYTES = 32'(DEPTH_WORDS * 4);
    localparam logic [3:0]  CNT_INIT     = 4'((WAIT_CYCLES >= 2) ? (WAIT_CYCLES - 2) : 0);
    localparam bit          SINGLE_CYCLE = (WAIT_CYCLES == 1);

    generate
        if (WAIT_CYCLES < 1 || WAIT_CYCLES > 16) begin : g_bad_wait
            $error("miriscv_data_mem: WAIT_CYCLES must be in 1..16");
        end
        if (DEPTH_WORDS < 2 || DEPTH_WORDS > 65536 || (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
            $error("miriscv_data_mem: DEPTH_WORDS must be a power of two in 2..65536");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q;
    logic [3:0]     cnt_q;
    logic           lat_we;
    logic [3:0]     lat_be;
    logic [AW-1:0]  lat_idx;
    logic [31:0]    lat_wdata;
    logic           lat_in_range;

    logic [31:0]    mem [DEPTH_WORDS];

    logic [31:0]    req_offset;
    logic           req_in_range;
    logic [AW-1:0]  req_idx;

    logic           acc_we;
    logic [3:0]     acc_be;
    logic [AW-1:0]  acc_idx;
    logic [31:0]    acc_wdata;
    logic           acc_in_range;
    logic           do_access;

    // Unsigned wrap makes addresses below BASE_ADDR land far above the window.
    always_comb begin
        req_offset   = data_addr_i - BASE_ADDR;
        req_in_range = (req_offset < WINDOW_BYTES);
        req_idx      = req_offset[AW+1:2];
    end

    // With a single wait cycle the access completes on the accepting edge straight from the bus.
    always_comb begin
        if (state_q == IDLE) begin
            acc_we       = data_we_i;
            acc_be       = data_be_i;
            acc_idx      = req_idx;
            acc_wdata    = data_wdata_i;
            acc_in_range = req_in_range;
        end else begin
            acc_we       = lat_we;
            acc_be       = lat_be;
            acc_idx      = lat_idx;
            acc_wdata    = lat_wdata;
            acc_in_range = lat_in_range;
        end
        do_access = arstn_i &&
                    (((state_q == IDLE) && data_req_i && SINGLE_CYCLE) ||
                     ((state_q == BUSY) && (cnt_q == 4'd0)));
    end

    assign data_stall_o = arstn_i && (((state_q == IDLE) && data_req_i) || (state_q == BUSY));

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            lat_we       <= 1'b0;
            lat_be       <= 4'd0;
            lat_idx      <= '0;
            lat_wdata    <= 32'd0;
            lat_in_range <= 1'b0;
            data_rdata_o <= 32'd0;
            data_err_o   <= 1'b0;
        end else begin
            if (do_access) begin
                data_err_o <= !acc_in_range;
                if (!acc_we) begin
                    data_rdata_o <= acc_in_range ? mem[acc_idx] : 32'd0;
                end
            end
            case (state_q)
                IDLE: begin
                    if (data_req_i) begin
                        lat_we       <= data_we_i;
                        lat_be       <= data_be_i;
                        lat_idx      <= req_idx;
                        lat_wdata    <= data_wdata_i;
                        lat_in_range <= req_in_range;
                        if (SINGLE_CYCLE) begin
                            state_q <= DONE;
                        end else begin
                            cnt_q   <= CNT_INIT;
                            state_q <= BUSY;
                        end
                    end else begin
                        data_err_o <= 1'b0;
                    end
                end
                BUSY: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    data_err_o <= 1'b0;
                    state_q    <= IDLE;
                end
                default: begin
                    data_err_o <= 1'b0;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

    // Storage has no reset so its contents survive one; do_access is already gated by reset.
    always_ff @(posedge clk_i) begin
        if (do_access && acc_we && acc_in_range) begin
            for (int k = 0; k < 4; k++) begin
                if (acc_be[k]) begin
                    mem[acc_idx][8*k +: 8] <= acc_wdata[8*k +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_miriscv_data_mem.sv
// Directed bench for miriscv_data_mem using three instances with different wait/window settings.
module tb_miriscv_data_mem;

    logic        clk;
    logic        arstn;
    logic        req   [3];
    logic        we    [3];
    logic [3:0]  be    [3];
    logic [31:0] addr  [3];
    logic [31:0] wdata [3];
    logic [31:0] rdata [3];
    logic        stall [3];
    logic        err   [3];

    int nvec = 0;
    int nmis = 0;

    typedef struct {
        int          dut;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_stall;
    } vec_t;

    vec_t vecs[$];

    // d0: 1 wait cycle, base 0, 1024 words
    miriscv_data_mem #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_CYCLES(1)) u_d0 (
        .clk_i(clk), .arstn_i(arstn), .data_req_i(req[0]), .data_we_i(we[0]),
        .data_be_i(be[0]), .data_addr_i(addr[0]), .data_wdata_i(wdata[0]),
        .data_rdata_o(rdata[0]), .data_stall_o(stall[0]), .data_err_o(err[0]));

    // d1: 4 wait cycles, base 0x1000, 16 words
    miriscv_data_mem #(.DEPTH_WORDS(16), .BASE_ADDR(32'h1000), .WAIT_CYCLES(4)) u_d1 (
        .clk_i(clk), .arstn_i(arstn), .data_req_i(req[1]), .data_we_i(we[1]),
        .data_be_i(be[1]), .data_addr_i(addr[1]), .data_wdata_i(wdata[1]),
        .data_rdata_o(rdata[1]), .data_stall_o(stall[1]), .data_err_o(err[1]));

    // d2: 3 wait cycles, base 0, 16 words
    miriscv_data_mem #(.DEPTH_WORDS(16), .BASE_ADDR(32'h0), .WAIT_CYCLES(3)) u_d2 (
        .clk_i(clk), .arstn_i(arstn), .data_req_i(req[2]), .data_we_i(we[2]),
        .data_be_i(be[2]), .data_addr_i(addr[2]), .data_wdata_i(wdata[2]),
        .data_rdata_o(rdata[2]), .data_stall_o(stall[2]), .data_err_o(err[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int d, input logic w, input logic [3:0] b, input logic [31:0] a,
                                input logic [31:0] wd, input logic [31:0] er, input logic ee, input int es);
        vec_t v;
        v.dut = d; v.we = w; v.be = b; v.addr = a; v.wdata = wd;
        v.exp_rdata = er; v.exp_err = ee; v.exp_stall = es;
        return v;
    endfunction

    // One full access: count stall cycles, check DONE outputs, then check the following IDLE cycle.
    task automatic applyStimulus(input vec_t v);
        int cycles;
        int d;
        d = v.dut;
        @(negedge clk);
        req[d] = 1'b1; we[d] = v.we; be[d] = v.be; addr[d] = v.addr; wdata[d] = v.wdata;
        #1;
        cycles = 0;
        while (stall[d] && cycles < 40) begin
            cycles++;
            @(negedge clk);
        end
        checkOutput($sformatf("d%0d stall_cycles @%h", d, v.addr), 32'(cycles), 32'(v.exp_stall));
        checkOutput($sformatf("d%0d rdata @%h", d, v.addr), rdata[d], v.exp_rdata);
        checkOutput($sformatf("d%0d err @%h", d, v.addr), 32'(err[d]), 32'(v.exp_err));
        req[d] = 1'b0; we[d] = 1'b0;
        @(negedge clk);
        checkOutput($sformatf("d%0d idle_err @%h", d, v.addr), 32'(err[d]), 32'd0);
        checkOutput($sformatf("d%0d idle_stall @%h", d, v.addr), 32'(stall[d]), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            req[i] = 1'b0; we[i] = 1'b0; be[i] = 4'h0; addr[i] = 32'h0; wdata[i] = 32'h0;
        end

        vecs.push_back(mk(0, 1, 4'hF, 32'h10,  32'hDEADBEEF, 32'h00000000, 0, 1));
        vecs.push_back(mk(0, 0, 4'hF, 32'h10,  32'h0,        32'hDEADBEEF, 0, 1));
        vecs.push_back(mk(0, 1, 4'h4, 32'h12,  32'h00AA00AA, 32'hDEADBEEF, 0, 1));
        vecs.push_back(mk(0, 0, 4'hF, 32'h10,  32'h0,        32'hDEAABEEF, 0, 1));
        vecs.push_back(mk(0, 1, 4'hF, 32'h14,  32'h01234567, 32'hDEAABEEF, 0, 1));
        vecs.push_back(mk(0, 1, 4'h9, 32'h14,  32'hA5A5A5A5, 32'hDEAABEEF, 0, 1));
        vecs.push_back(mk(0, 0, 4'hF, 32'h16,  32'h0,        32'hA52345A5, 0, 1));
        vecs.push_back(mk(0, 1, 4'h0, 32'h10,  32'hFFFFFFFF, 32'hA52345A5, 0, 1));
        vecs.push_back(mk(0, 0, 4'hF, 32'h10,  32'h0,        32'hDEAABEEF, 0, 1));
        vecs.push_back(mk(0, 1, 4'hF, 32'hFFC, 32'hCAFEF00D, 32'hDEAABEEF, 0, 1));
        vecs.push_back(mk(0, 0, 4'hF, 32'hFFC, 32'h0,        32'hCAFEF00D, 0, 1));
        vecs.push_back(mk(0, 1, 4'hF, 32'h0,   32'h0BADCAFE, 32'hCAFEF00D, 0, 1));
        vecs.push_back(mk(0, 0, 4'hF, 32'h1000, 32'h0,       32'h00000000, 1, 1));
        vecs.push_back(mk(0, 1, 4'hF, 32'h1000, 32'h99999999, 32'h00000000, 1, 1));
        vecs.push_back(mk(0, 0, 4'hF, 32'h0,   32'h0,        32'h0BADCAFE, 0, 1));
        vecs.push_back(mk(1, 1, 4'hF, 32'h1000, 32'h11111111, 32'h00000000, 0, 4));
        vecs.push_back(mk(1, 1, 4'hF, 32'h103C, 32'h3C3C3C3C, 32'h00000000, 0, 4));
        vecs.push_back(mk(1, 1, 4'hF, 32'h1040, 32'h12345678, 32'h00000000, 1, 4));
        vecs.push_back(mk(1, 0, 4'hF, 32'h1040, 32'h0,        32'h00000000, 1, 4));
        vecs.push_back(mk(1, 0, 4'hF, 32'h0FFC, 32'h0,        32'h00000000, 1, 4));
        vecs.push_back(mk(1, 0, 4'hF, 32'h1000, 32'h0,        32'h11111111, 0, 4));
        vecs.push_back(mk(1, 0, 4'hF, 32'h103C, 32'h0,        32'h3C3C3C3C, 0, 4));
        vecs.push_back(mk(2, 1, 4'hF, 32'h20,  32'h000000AA, 32'h00000000, 0, 3));
        vecs.push_back(mk(2, 0, 4'hF, 32'h20,  32'h0,        32'h000000AA, 0, 3));

        // Reset held for two cycles, then idle with no requests.
        arstn = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("d%0d reset_rdata", i), rdata[i], 32'h0);
            checkOutput($sformatf("d%0d reset_stall", i), 32'(stall[i]), 32'd0);
            checkOutput($sformatf("d%0d reset_err", i), 32'(err[i]), 32'd0);
        end
        arstn = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("d%0d idle_rdata", i), rdata[i], 32'h0);
            checkOutput($sformatf("d%0d idle_stall", i), 32'(stall[i]), 32'd0);
        end

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
        end

        // d1 read with the request dropped during the second BUSY cycle.
        @(negedge clk);
        req[1] = 1'b1; we[1] = 1'b0; be[1] = 4'hF; addr[1] = 32'h1000;
        #1 checkOutput("drop T stall", 32'(stall[1]), 32'd1);
        @(negedge clk);
        checkOutput("drop T+1 stall", 32'(stall[1]), 32'd1);
        @(negedge clk);
        req[1] = 1'b0;
        #1 checkOutput("drop T+2 stall", 32'(stall[1]), 32'd1);
        @(negedge clk);
        checkOutput("drop T+3 stall", 32'(stall[1]), 32'd1);
        @(negedge clk);
        checkOutput("drop DONE stall", 32'(stall[1]), 32'd0);
        checkOutput("drop DONE rdata", rdata[1], 32'h11111111);
        checkOutput("drop DONE err", 32'(err[1]), 32'd0);
        @(negedge clk);
        checkOutput("drop IDLE stall", 32'(stall[1]), 32'd0);
        checkOutput("drop IDLE rdata", rdata[1], 32'h11111111);

        // d2 write of 0x55 aborted by reset during BUSY.
        @(negedge clk);
        req[2] = 1'b1; we[2] = 1'b1; be[2] = 4'hF; addr[2] = 32'h20; wdata[2] = 32'h00000055;
        #1 checkOutput("abort T stall", 32'(stall[2]), 32'd1);
        @(negedge clk);
        checkOutput("abort BUSY stall", 32'(stall[2]), 32'd1);
        #1 arstn = 1'b0;
        #1 checkOutput("abort reset stall", 32'(stall[2]), 32'd0);
        req[2] = 1'b0; we[2] = 1'b0;
        @(negedge clk);
        arstn = 1'b1;
        applyStimulus(mk(2, 0, 4'hF, 32'h20, 32'h0, 32'h000000AA, 0, 3));
        applyStimulus(mk(0, 0, 4'hF, 32'h10, 32'h0, 32'hDEAABEEF, 0, 1));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: got running, expected finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule

// File: doc/miriscv_data_mem.md
Name: miriscv_data_mem

Overview:
- Data-memory responder at the far end of the core's data bus; the load/store unit is the initiator.
- Accepts word-addressed requests with per-byte write enables and returns whole 32-bit read words. The initiator does byte/half selection and sign extension.
- Inserts a programmable number of wait states and holds the core with a stall signal until each access completes.
- Flags accesses that fall outside its window.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words stored; power of two, 2 to 65536.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; aligned to DEPTH_WORDS*4.
- WAIT_CYCLES, 1: total cycles data_stall_o is high per access; legal range 1..16.

Ports:
- clk_i  in  1  clock, all state on rising edge
- arstn_i  in  1  asynchronous active-low reset
- data_req_i  in  1  request valid
- data_we_i  in  1  1 = write, 0 = read
- data_be_i  in  4  byte-lane enables; bit k covers bits [8k+7:8k]
- data_addr_i  in  32  byte address; bits [1:0] ignored
- data_wdata_i  in  32  write data, already lane-replicated by initiator
- data_rdata_o  out  32  read word (registered)
- data_stall_o  out  1  1 = core must hold request and PC
- data_err_o  out  1  1 = completed access was out of range (registered)

Behaviour:
- Reset (arstn_i low, asynchronous):
  - State goes to IDLE; counter = 0.
  - data_rdata_o = 0; data_err_o = 0; data_stall_o = 0.
  - Storage array is NOT reset. Its contents survive reset.
- Range check: the access is in range iff (data_addr_i - BASE_ADDR) < DEPTH_WORDS*4, using unsigned 32-bit wrap.
- Word index: (data_addr_i - BASE_ADDR)[log2(DEPTH_WORDS)+1:2].
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - data_stall_o = data_req_i (combinational, same cycle).
  - On an edge with data_req_i = 1, latch we, be, addr, wdata and the range result.
  - If WAIT_CYCLES = 1: perform the access at that edge and go to DONE.
  - Otherwise: load counter = WAIT_CYCLES-2 and go to BUSY.
  - If data_req_i = 0: stay in IDLE; no output changes.
- BUSY:
  - data_stall_o = 1.
  - Counter != 0: decrement the counter and stay in BUSY.
  - Counter = 0: perform the access with the latched values and go to DONE.
  - data_req_i and all other inputs are ignored; a request dropped mid-BUSY still completes.
- DONE:
  - data_stall_o = 0; data_rdata_o and data_err_o are valid.
  - data_req_i is ignored, because the core still presents the same request this cycle.
  - Next state is always IDLE.
- Resulting latency: the request is first seen in cycle T; stall is high in cycles T..T+WAIT_CYCLES-1; DONE is cycle T+WAIT_CYCLES.
- Access, performed at the completing edge:
  - In-range read: data_rdata_o <= mem[idx].
  - In-range write: for each k with be[k] = 1, mem[idx][8k+7:8k] <= wdata[8k+7:8k]. data_rdata_o is unchanged.
  - be = 4'b0000 write: no change to memory.
  - data_err_o <= out-of-range flag.
  - Out-of-range read: data_rdata_o <= 0.
  - Out-of-range write: memory is unmodified.
- data_err_o: forced to 0 on any edge that enters IDLE, so it is high only during DONE.
- Back-to-back requests: after DONE, the IDLE cycle accepts the next request immediately. Throughput is one access per WAIT_CYCLES+1 cycles.
- Reset mid-access (BUSY or DONE): the in-flight write is dropped unless its completing edge already occurred; the FSM returns to IDLE.
- Illegal WAIT_CYCLES (outside 1..16): flag with an elaboration-time assertion; no runtime behaviour is defined.

Test Plan:
- Reset then idle, WAIT_CYCLES=1:
  - Stimulus: arstn_i low 2 cycles, then release with data_req_i = 0.
  - Response: rdata_o = 0, stall_o = 0, err_o = 0 throughout.
- Full write then read, WAIT_CYCLES=1:
  - Stimulus: write addr 0x10, be 4'hF, wdata 0xDEADBEEF; then read 0x10.
  - Response: stall high exactly 1 cycle per access; rdata_o = 0xDEADBEEF in the read's DONE cycle.
- Partial-lane write, WAIT_CYCLES=1:
  - Stimulus: after the full write above, write 0x12 with be 4'b0100 and wdata 0x00AA00AA; then read 0x10.
  - Response: rdata_o = 0xDEAABEEF.
- Wait states, WAIT_CYCLES=4:
  - Stimulus: read 0x10, with data_req_i dropped during the second BUSY cycle.
  - Response: stall high for 4 cycles; DONE in cycle 5 with correct data; FSM back to IDLE.
- Out-of-range write, BASE_ADDR=0x1000, DEPTH_WORDS=16:
  - Stimulus: write 0x1040 with wdata 0x12345678.
  - Response: err_o = 1 in DONE only; all 16 words unchanged; a following read of 0x1040 gives rdata_o = 0 and err_o = 1.
- Reset mid-access, WAIT_CYCLES=3:
  - Stimulus: assert reset during BUSY of a write to 0x20 carrying 0x55.
  - Response: stall_o drops immediately; a read of 0x20 after reset returns the pre-write contents.
